// File: rtl/uart_pkg.sv
// Shared UART types and default frame parameters for the receiver and transmitter.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value is
// chosen per input so an idle line does not look active out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked by the shared 16x oversample tick.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on data and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q;
  logic                 rx_s;
  logic                 bit_val;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_M3 = CNT_W'(OVERSAMPLE - 3);
  localparam logic [CNT_W-1:0] CNT_M2 = CNT_W'(OVERSAMPLE - 2);

  logic maj_a_q, maj_a_d;
  logic maj_b_q, maj_b_d;
  logic in_bit;

  assign in_bit = (state_q == DATA) || (state_q == STOP);

  always_comb begin
    maj_a_d = maj_a_q;
    maj_b_d = maj_b_q;
    if (s_tick && in_bit && (cnt_q == CNT_M3)) maj_a_d = rx_s;
    if (s_tick && in_bit && (cnt_q == CNT_M2)) maj_b_d = rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else begin
      maj_a_q <= maj_a_d;
      maj_b_q <= maj_b_d;
    end
  end

  // Third vote is the live sample taken at the last tick of the bit.
  assign bit_val = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d  = DATA;
              bitcnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d  = {bit_val, shift_q[DATA_BITS-1:1]};
            cnt_d    = '0;
            bitcnt_d = bitcnt_q + BIT_W'(1);
            if (bitcnt_q == BIT_LAST) state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit keeps us ready for a back-to-back start edge.
        if (s_tick) begin
          if (cnt_q == CNT_LAST) begin
            rx_data_d   = shift_q;
            frame_err_d = ~bit_val;
            rx_done_d   = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-aligned frames, line-level reference model.
module tb_uart_rx;

  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int FRAME_T = OS * (DB + 2);
  localparam int MID     = OS / 2 - 1;

  logic          clk;
  logic          rst;
  logic          s_tick;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DB:0]   exp_q[$];
  logic [DB:0]   got_q[$];
  logic          frame_line [FRAME_T];
  logic [DB-1:0] hold_data;
  logic          hold_err;
  logic          prev_done;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // clock / reset / tick
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // completion monitor
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      got_q.push_back({frame_err, rx_data});
      n_vec++;
      if (prev_done === 1'b1) begin
        n_err++;
        $display("FAIL rx_done_width: got 2+ cycle pulse want 1 cycle");
      end
    end
    prev_done = rx_done;
  end

  // driver tasks
  task automatic wait_tick();
    int guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!s_tick && guard < 16);
    if (!s_tick) begin
      n_err++;
      $display("FAIL tick_timeout: got no s_tick within 16 clk want one");
    end
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Line level per tick: start, data LSB-first, stop held only up to its
  // sample point, then idle high for the rest of the bit.
  task automatic build_frame(input logic [DB-1:0] b, input logic stop);
    for (int i = 0; i < FRAME_T; i++) begin
      if (i < OS)                frame_line[i] = 1'b0;
      else if (i < OS * (DB + 1)) frame_line[i] = b[(i - OS) / OS];
      else if (i <= MID + OS * (DB + 1)) frame_line[i] = stop;
      else                       frame_line[i] = 1'b1;
    end
  endtask

  task automatic drive_line(input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx = frame_line[i];
      wait_tick();
    end
  endtask

  // reference model: a bit is read at its mid-point tick
  function automatic logic sample_at(input int idx);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(frame_line[idx - 2]) + int'(frame_line[idx - 1]) + int'(frame_line[idx]);
    return (ones >= 2);
`else
    return frame_line[idx];
`endif
  endfunction

  task automatic model_frame();
    logic [DB-1:0] d;
    logic          stop;
    if (frame_line[MID] == 1'b0) begin
      for (int k = 0; k < DB; k++) d[k] = sample_at(MID + OS * (k + 1));
      stop = sample_at(MID + OS * (DB + 1));
      exp_q.push_back({~stop, d});
      hold_data = d;
      hold_err  = ~stop;
    end
  endtask

  task automatic send(input logic [DB-1:0] b, input logic stop);
    build_frame(b, stop);
    model_frame();
    drive_line(0, FRAME_T);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    hold_data = '0;
    hold_err  = 1'b0;
    n_vec++; if (rx_data !== '0)   begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    idle_ticks(4);
  endtask

  task automatic test_single();
    logic [DB:0] e, g;
    send(8'hA5, 1'b1);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL single_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_false_start();
    for (int i = 0; i < FRAME_T; i++) frame_line[i] = (i >= 4);
    model_frame();
    drive_line(0, 40);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL false_start_done: got %0d pulses want 0", got_q.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL false_start_busy: got %b want 0", busy); end
    n_vec++; if (rx_data !== hold_data) begin n_err++; $display("FAIL false_start_data: got %h want %h", rx_data, hold_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_err();
    logic [DB:0] e, g;
    send(8'h3C, 1'b0);
    idle_ticks(4);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    send(8'h01, 1'b1);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ferr_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL ferr_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_vec++; if (frame_err !== hold_err) begin n_err++; $display("FAIL ferr_clear: got %b want %b", frame_err, hold_err); end
  endtask

  task automatic test_back_to_back();
    logic [DB:0] e, g;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    n_vec++;
    if (got_q.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL b2b_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DB:0] e, g;
    build_frame(8'h81, 1'b1);
    drive_line(0, OS * 5 + OS / 2);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    hold_data = '0;
    hold_err  = 1'b0;
    n_vec++; if (rx_data !== '0)   begin n_err++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    idle_ticks(8);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_done: got %0d pulses want 0", got_q.size()); end
    got_q.delete();
    send(8'h7E, 1'b1);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL rstmid_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_glitch();
    logic [DB:0]   e, g;
    logic [DB-1:0] want_late;
`ifdef UART_RX_MAJORITY_EN
    want_late = 8'h00;
`else
    want_late = 8'h08;
`endif
    // bit 3 glitched at cnt==OVERSAMPLE-2
    build_frame(8'h00, 1'b1);
    frame_line[MID + OS * 4 - 1] = 1'b1;
    model_frame();
    drive_line(0, FRAME_T);
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL glitch_m2: got %h want 00", rx_data); end
    // bit 3 glitched at cnt==OVERSAMPLE-1
    build_frame(8'h00, 1'b1);
    frame_line[MID + OS * 4] = 1'b1;
    model_frame();
    drive_line(0, FRAME_T);
    n_vec++; if (rx_data !== want_late) begin n_err++; $display("FAIL glitch_m1: got %h want %h", rx_data, want_late); end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL glitch_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL glitch_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [DB:0]   e, g;
    logic [DB-1:0] b;
    logic          stop;
    int            pos;
    for (int n = 0; n < 8; n++) begin
      b    = DB'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      build_frame(b, stop);
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(OS, MID + OS * (DB + 1));
        frame_line[pos] = ~frame_line[pos];
      end
      model_frame();
      drive_line(0, FRAME_T);
      idle_ticks($urandom_range(0, 3));
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL random_frame: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL random_busy: got %b want 0", busy); end
  endtask

  // sequence and report
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
